// File: rtl/valu_pkg.sv
// Shared types and constants for the vector-ALU mantissa-alignment scheduler.
package valu_pkg;

  localparam int unsigned MANT_W    = 24;
  localparam int unsigned SHAMT_W   = 8;
  // Widest per-job tag a scheduler instance may carry (TAG_W <= TAG_MAX_W).
  localparam int unsigned TAG_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_e;

  typedef struct packed {
    logic [MANT_W-1:0]    mant;
    logic [SHAMT_W-1:0]   amt;
    logic [TAG_MAX_W-1:0] tag;
  } align_job_t;

endpackage

// File: rtl/valu_rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest requesting index at or above ptr_i, wrapping.
module valu_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned k;
      k = (32'(ptr_i) + i) % NREQ;
      if (!any_o && req_i[k]) begin
        any_o      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/valu_align_shift_sched.sv
// Round-robin scheduler sharing one 24-bit logical right shifter among NREQ lanes.
// Optional macro VALU_ALIGN_STICKY_EN builds the sticky (shifted-out OR) logic; otherwise out_sticky is 0.
module valu_align_shift_sched
  import valu_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*MANT_W-1:0]  req_mant,
  input  logic [NREQ*SHAMT_W-1:0] req_amt,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MANT_W-1:0]       out_mant,
  output logic                    out_sticky,
  output logic [IDX_W-1:0]        out_lane,
  output logic [TAG_W-1:0]        out_tag
);

  align_state_e       state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   lane_q, lane_d;
  align_job_t         job_q, job_d;
  logic [MANT_W-1:0]  out_mant_q, out_mant_d;
  logic               out_sticky_q, out_sticky_d;
  logic [IDX_W-1:0]   out_lane_q, out_lane_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic [MANT_W-1:0]  shr_mant;
  logic               shr_sticky;

  valu_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // Shared shifter sees only the latched job; SV shifts by >= width already yield zero.
  assign shr_mant = job_q.mant >> job_q.amt;
`ifdef VALU_ALIGN_STICKY_EN
  assign shr_sticky = |(job_q.mant & ~({MANT_W{1'b1}} << job_q.amt));
`else
  assign shr_sticky = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lane_d       = lane_q;
    job_d        = job_q;
    out_mant_d   = out_mant_q;
    out_sticky_d = out_sticky_q;
    out_lane_d   = out_lane_q;
    out_tag_d    = out_tag_q;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          req_ready     = grant;
          job_d.mant    = req_mant[grant_idx*MANT_W +: MANT_W];
          job_d.amt     = req_amt[grant_idx*SHAMT_W +: SHAMT_W];
          job_d.tag     = TAG_MAX_W'(req_tag[grant_idx*TAG_W +: TAG_W]);
          lane_d        = grant_idx;
          ptr_d         = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        out_mant_d   = shr_mant;
        out_sticky_d = shr_sticky;
        out_lane_d   = lane_q;
        out_tag_d    = job_q.tag[TAG_W-1:0];
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      lane_q       <= '0;
      job_q        <= '0;
      out_mant_q   <= '0;
      out_sticky_q <= 1'b0;
      out_lane_q   <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lane_q       <= lane_d;
      job_q        <= job_d;
      out_mant_q   <= out_mant_d;
      out_sticky_q <= out_sticky_d;
      out_lane_q   <= out_lane_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_mant   = out_mant_q;
  assign out_sticky = out_sticky_q;
  assign out_lane   = out_lane_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_valu_align_shift_sched.sv
// Directed self-checking bench for valu_align_shift_sched (expected values hand-computed).
module tb_valu_align_shift_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned TAG_W = 4;

`ifdef VALU_ALIGN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*24-1:0] req_mant;
  logic [NREQ*8-1:0] req_amt;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic              out_valid;
  logic              out_ready;
  logic [23:0]       out_mant;
  logic              out_sticky;
  logic [1:0]        out_lane;
  logic [TAG_W-1:0]  out_tag;

  int errors = 0;
  int checks = 0;

  valu_align_shift_sched #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mant   (req_mant),
    .req_amt    (req_amt),
    .req_tag    (req_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_sticky (out_sticky),
    .out_lane   (out_lane),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max_cyc);
    int n = 0;
    while (req_ready == '0 && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  task automatic set_lane(input int lane, input logic [23:0] m, input logic [7:0] a,
                          input logic [TAG_W-1:0] t);
    req_mant[24*lane +: 24]      = m;
    req_amt[8*lane +: 8]         = a;
    req_tag[TAG_W*lane +: TAG_W] = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single-lane job: grant, 2 cycles to out_valid, then consume.
  task automatic do_job(input string name, input int lane, input logic [23:0] m, input logic [7:0] a,
                        input logic [TAG_W-1:0] t, input logic [23:0] exp_m, input logic exp_s);
    set_lane(lane, m, a, t);
    req_valid[lane] = 1'b1;
    out_ready = 1'b0;
    #1;
    wait_ready(8);
    check({name, ".grant"}, 32'(req_ready), 32'(1 << lane));
    tick();
    req_valid[lane] = 1'b0;
    #1;
    check({name, ".shift_valid"}, 32'(out_valid), 0);
    tick();
    check({name, ".valid"}, 32'(out_valid), 1);
    check({name, ".mant"}, 32'(out_mant), 32'(exp_m));
    check({name, ".sticky"}, 32'(out_sticky), 32'(exp_s));
    check({name, ".lane"}, 32'(out_lane), 32'(lane));
    check({name, ".tag"}, 32'(out_tag), 32'(t));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, ".drop"}, 32'(out_valid), 0);
  endtask

  logic [23:0] fair_exp_m [4] = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};
  logic        fair_exp_s [4] = '{1'b0, STK, STK, STK};
  logic [23:0] held_m;

  initial begin
    req_mant = '0;
    req_amt  = '0;
    req_tag  = '0;
    do_reset();
    check("rst.valid", 32'(out_valid), 0);
    check("rst.ready", 32'(req_ready), 0);
    check("rst.mant", 32'(out_mant), 0);
    check("rst.sticky", 32'(out_sticky), 0);
    check("rst.lane", 32'(out_lane), 0);
    check("rst.tag", 32'(out_tag), 0);

    do_job("t1", 0, 24'hC00000, 8'd3, 4'd5, 24'h180000, 1'b0);
    do_job("t2", 1, 24'h80000F, 8'd4, 4'd9, 24'h080000, STK);
    do_job("t3a", 2, 24'h800001, 8'd24, 4'd2, 24'h000000, STK);
    do_job("t3b", 3, 24'h800001, 8'd255, 4'd15, 24'h000000, STK);
    do_job("t3c", 0, 24'h800001, 8'd0, 4'd0, 24'h800001, 1'b0);
    do_job("t3d", 1, 24'hFFFFFF, 8'd23, 4'd1, 24'h000001, STK);

    // Fairness: all lanes valid from reset, grants must rotate 0,1,2,3,0,...
    do_reset();
    for (int k = 0; k < 4; k++) set_lane(k, 24'h800000 | 24'(k), 8'(k + 1), 4'(k + 8));
    req_valid = '1;
    out_ready = 1'b1;
    #1;
    for (int j = 0; j < 8; j++) begin
      wait_ready(6);
      check("fair.grant", 32'(req_ready), 32'(1 << (j % 4)));
      tick();
      tick();
      check("fair.valid", 32'(out_valid), 1);
      check("fair.lane", 32'(out_lane), 32'(j % 4));
      check("fair.mant", 32'(out_mant), 32'(fair_exp_m[j % 4]));
      check("fair.sticky", 32'(out_sticky), 32'(fair_exp_s[j % 4]));
      check("fair.tag", 32'(out_tag), 32'((j % 4) + 8));
      tick();
    end

    // Backpressure: hold DONE for 10 cycles with lane 1 waiting.
    do_reset();
    set_lane(0, 24'hABCDEF, 8'd4, 4'd7);
    set_lane(1, 24'h123456, 8'd0, 4'd3);
    req_valid = 4'b0001;
    #1;
    wait_ready(4);
    check("bp.grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    tick();
    held_m = 24'h0ABCDE;
    for (int c = 0; c < 10; c++) begin
      check("bp.valid", 32'(out_valid), 1);
      check("bp.mant", 32'(out_mant), 32'(held_m));
      check("bp.ready", 32'(req_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.drop", 32'(out_valid), 0);
    check("bp.grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    check("bp.mant1", 32'(out_mant), 32'h123456);
    check("bp.lane1", 32'(out_lane), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during SHIFT discards the job and rewinds the pointer.
    do_reset();
    set_lane(2, 24'h000FFF, 8'd0, 4'd6);
    req_valid = 4'b0100;
    #1;
    wait_ready(4);
    check("rm.grant2", 32'(req_ready), 32'b0100);
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    check("rm.valid", 32'(out_valid), 0);
    check("rm.mant", 32'(out_mant), 0);
    rst = 1'b0;
    tick();
    check("rm.noout", 32'(out_valid), 0);
    tick();
    check("rm.noout2", 32'(out_valid), 0);
    set_lane(1, 24'h000010, 8'd4, 4'd4);
    set_lane(3, 24'h000020, 8'd5, 4'd12);
    req_valid = 4'b1010;
    #1;
    check("rm.ptr0", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    check("rm.lane1", 32'(out_lane), 1);
    check("rm.mant1", 32'(out_mant), 32'h000001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    req_valid = '0;
    #1;
    do_job("rm.again2", 2, 24'h000FFF, 8'd0, 4'd6, 24'h000FFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
